// File: rtl/vjtag_cmd_parser.sv
// vjtag_cmd_parser: byte-stream command decoder behind the virtual-JTAG UART.
// A receive FIFO buffers host bytes. The parser pops them and decodes two commands:
// 'L' + hex + CR/LF sets LEDG, and 'H' + hex + CR/LF sets the 4-digit display.
// Each command is answered with a one-byte status, 'K' or 'E'.
//
// Build option: define HEX_SEG_EN to compile in the display register and the
// nibble-to-7-segment decoder. Without it, HEX0..HEX3 are blank (7'h7F), and
// 'H' commands are still parsed and acknowledged.
//
// Handshakes (valid/ready): a transfer happens on a rising m_clock edge where
// valid && ready. A source holds its data and valid until it sees that edge.
// rx_ready depends only on registered FIFO occupancy. tx_valid/tx_data are
// registered, and they stay stable until tx_ready is seen high.
`timescale 1ns/1ps
module vjtag_cmd_parser #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [9:0] LEDG,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [1:0] dbg_state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef HEX_SEG_EN
    localparam int ACC_W = 16;
`else
    // Only LEDG consumes the accumulator, so keep just the bits it can see.
    localparam int ACC_W = 10;
`endif

    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] ST_K  = 8'h4B;
    localparam logic [7:0] ST_E  = 8'h45;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD_L   = 2'd1,
        CMD_H   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    // ---------------- receive FIFO ----------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [7:0]    rd_byte;

    // ---------------- parser state ----------------
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]       ndig_q, ndig_d;
    logic [9:0]       ledg_q, ledg_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             is_hex, is_term;
    logic [3:0]       nib;
    logic [2:0]       dig_limit;

    assign rx_ready = (count_q != FULL_CNT);
    assign push     = rx_valid && rx_ready;
    // The parser stalls while a status byte is still waiting for the host.
    assign pop      = (count_q != '0) && !tx_valid_q;
    assign rd_byte  = mem_q[rd_ptr_q];

    // FIFO storage write; the contents need no reset because occupancy gates reads.
    always_ff @(posedge m_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap because the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Classify the byte at the FIFO head: hex digit (with its value) or line terminator.
    always_comb begin
        is_hex = 1'b1;
        nib    = 4'h0;
        if (rd_byte >= 8'h30 && rd_byte <= 8'h39) begin
            nib = rd_byte[3:0];
        end else if ((rd_byte >= 8'h41 && rd_byte <= 8'h46) ||
                     (rd_byte >= 8'h61 && rd_byte <= 8'h66)) begin
            nib = rd_byte[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
        is_term = (rd_byte == CH_CR) || (rd_byte == CH_LF);
    end

    assign dig_limit = (state_q == CMD_L) ? 3'd3 : 3'd4;

`ifdef HEX_SEG_EN
    logic [15:0] disp_q, disp_d;
    logic [6:0]  hex_q [4];

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction
`endif

    // Parser next-state, accumulator, commit and status queuing.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ndig_d     = ndig_q;
        ledg_d     = ledg_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
`ifdef HEX_SEG_EN
        disp_d     = disp_q;
`endif
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
        if (pop) begin
            case (state_q)
                IDLE: begin
                    if (rd_byte == CH_L || rd_byte == CH_H) begin
                        acc_d   = '0;
                        ndig_d  = 3'd0;
                        state_d = (rd_byte == CH_L) ? CMD_L : CMD_H;
                    end else if (!is_term) begin
                        state_d = DISCARD;
                    end
                end
                CMD_L, CMD_H: begin
                    if (is_hex) begin
                        if (ndig_q == dig_limit) begin
                            state_d = DISCARD;
                        end else begin
                            acc_d  = {acc_q[ACC_W-5:0], nib};
                            ndig_d = ndig_q + 3'd1;
                        end
                    end else if (is_term) begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b1;
                        if (ndig_q != 3'd0) begin
                            tx_data_d = ST_K;
                            if (state_q == CMD_L) begin
                                ledg_d = acc_q[9:0];
                            end
`ifdef HEX_SEG_EN
                            else begin
                                disp_d = acc_q;
                            end
`endif
                        end else begin
                            tx_data_d = ST_E;
                        end
                    end else begin
                        state_d = DISCARD;
                    end
                end
                default: begin
                    if (is_term) begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b1;
                        tx_data_d  = ST_E;
                    end
                end
            endcase
        end
    end

    // Parser state register; reset abandons any partial command silently.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            ndig_q     <= 3'd0;
            ledg_q     <= 10'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ndig_q     <= ndig_d;
            ledg_q     <= ledg_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef HEX_SEG_EN
    // Display value register and registered segment outputs (one cycle behind disp_q).
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            disp_q   <= 16'h0000;
            hex_q[0] <= 7'h40;
            hex_q[1] <= 7'h40;
            hex_q[2] <= 7'h40;
            hex_q[3] <= 7'h40;
        end else begin
            disp_q   <= disp_d;
            hex_q[0] <= seg7(disp_q[3:0]);
            hex_q[1] <= seg7(disp_q[7:4]);
            hex_q[2] <= seg7(disp_q[11:8]);
            hex_q[3] <= seg7(disp_q[15:12]);
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
`else
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
`endif

    assign LEDG        = ledg_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vjtag_cmd_parser.sv
// Testbench for vjtag_cmd_parser.
// The reference model works on whole lines. Bytes up to a terminator are
// collected, and each completed line is judged against the command grammar.
// That judgement gives the expected status byte and any LEDG/display update.
`timescale 1ns/1ps
module tb_vjtag_cmd_parser;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] ACK_K = 8'h4B;
  localparam logic [7:0] ACK_E = 8'h45;

  // ---------------- clock / reset ----------------
  logic       m_clock  = 1'b0;
  logic       p_reset  = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [9:0] LEDG;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic [1:0] dbg_state;

  always #10 m_clock = ~m_clock;

  vjtag_cmd_parser #(.FIFO_DEPTH(16)) dut (
    .m_clock     (m_clock),
    .p_reset     (p_reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .LEDG        (LEDG),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  line_q[$];
  logic [7:0]  pend_q[$];
  logic [9:0]  m_ledg = 10'd0;
  logic [15:0] m_disp = 16'd0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          rand_ready = 1'b0;
  logic        tx_ready_fix = 1'b1;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [27:0] exp_hex();
`ifdef HEX_SEG_EN
    return {seg_tab[m_disp[15:12]], seg_tab[m_disp[11:8]], seg_tab[m_disp[7:4]], seg_tab[m_disp[3:0]]};
`else
    return {4{7'h7F}};
`endif
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    int v;
    v = int'(c);
    if (v >= 48 && v <= 57)  return v - 48;
    if (v >= 65 && v <= 70)  return v - 55;
    if (v >= 97 && v <= 102) return v - 87;
    return -1;
  endfunction

  // Judge one completed line against the command grammar.
  function automatic void model_line();
    int       ndig;
    int       limit;
    bit       ok;
    int       val;
    if (line_q.size() == 0) return;
    if (line_q[0] != 8'h4C && line_q[0] != 8'h48) begin
      exp_q.push_back(ACK_E);
      return;
    end
    ndig  = line_q.size() - 1;
    limit = (line_q[0] == 8'h4C) ? 3 : 4;
    ok    = (ndig >= 1) && (ndig <= limit);
    val   = 0;
    for (int i = 1; i < line_q.size(); i++) begin
      if (hex_val(line_q[i]) < 0) ok = 1'b0;
      else val = val * 16 + hex_val(line_q[i]);
    end
    if (ok) begin
      if (line_q[0] == 8'h4C) m_ledg = val[9:0];
      else m_disp = val[15:0];
      exp_q.push_back(ACK_K);
    end else begin
      exp_q.push_back(ACK_E);
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == CR || b == LF) begin
      model_line();
      line_q.delete();
    end else begin
      line_q.push_back(b);
    end
  endfunction

  function automatic void model_reset();
    line_q.delete();
    exp_q.delete();
    m_ledg = 10'd0;
    m_disp = 16'd0;
  endfunction

  // ---------------- tx side: ready generation and monitor ----------------
  always @(posedge m_clock) begin
    #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : tx_ready_fix;
  end

  always @(negedge m_clock) begin
    if (!p_reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check("tx_extra_byte", 32'(exp_q.size()), 32'd1);
      else check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge m_clock);
    while (!rx_ready && waited < 500) begin
      @(negedge m_clock);
      waited++;
    end
    if (!rx_ready) begin
      check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      rx_valid = 1'b0;
      @(posedge m_clock); #1;
      return;
    end
    @(posedge m_clock); #1;
    rx_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  function automatic void add_pend(input string s);
    for (int i = 0; i < s.len(); i++) pend_q.push_back(s[i]);
  endfunction

  // Push pending bytes back-to-back until the FIFO refuses one.
  task automatic fill_until_full(output int accepted);
    accepted = 0;
    while (pend_q.size() > 0) begin
      rx_data  = pend_q[0];
      rx_valid = 1'b1;
      @(negedge m_clock);
      if (!rx_ready) break;
      @(posedge m_clock); #1;
      model_byte(pend_q.pop_front());
      accepted++;
    end
    rx_valid = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    bit saved;
    saved = rand_ready;
    rand_ready   = 1'b0;
    tx_ready_fix = 1'b1;
    repeat (80) @(posedge m_clock);
    @(negedge m_clock);
    check({tag, "_tx_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_ledg"}, {22'd0, LEDG}, {22'd0, m_ledg});
    check({tag, "_hex"}, {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, exp_hex()});
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    rand_ready = saved;
    @(posedge m_clock); #1;
  endtask

  function automatic logic [7:0] rand_hex_char();
    int n;
    n = $urandom_range(0, 15);
    if (n < 10) return 8'(48 + n);
    return ($urandom_range(0, 1) != 0) ? 8'(55 + n) : 8'(87 + n);
  endfunction

  task automatic send_random_line();
    int         kind;
    int         nd;
    logic [7:0] lead;
    kind = $urandom_range(0, 5);
    lead = ($urandom_range(0, 1) != 0) ? 8'h4C : 8'h48;
    case (kind)
      0, 1: begin
        nd = (lead == 8'h4C) ? $urandom_range(1, 3) : $urandom_range(1, 4);
        send_byte(lead);
        for (int i = 0; i < nd; i++) send_byte(rand_hex_char());
      end
      2: begin
        nd = ((lead == 8'h4C) ? 4 : 5) + $urandom_range(0, 1);
        send_byte(lead);
        for (int i = 0; i < nd; i++) send_byte(rand_hex_char());
      end
      3: send_byte(lead);
      4: begin
        nd = $urandom_range(0, 4);
        for (int i = 0; i <= nd; i++) send_byte(8'($urandom_range(0, 255)));
      end
      default: begin
        send_byte(lead);
        nd = $urandom_range(0, 2);
        for (int i = 0; i < nd; i++) send_byte(rand_hex_char());
        send_byte(8'($urandom_range(0, 255)));
      end
    endcase
    case ($urandom_range(0, 2))
      0: send_byte(CR);
      1: send_byte(LF);
      default: begin send_byte(CR); send_byte(LF); end
    endcase
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int accepted;
    p_reset = 1'b1;
    repeat (3) @(posedge m_clock);
    #1 p_reset = 1'b0;
    @(negedge m_clock);
    check("rst_ledg", {22'd0, LEDG}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_hex", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, exp_hex()});
    @(posedge m_clock); #1;

    send_str("L3FF"); send_byte(CR);
    drain_and_check("l3ff");
    check("l3ff_value", {22'd0, LEDG}, 32'h3FF);

    send_str("H1a2B"); send_byte(LF);
    drain_and_check("h1a2b");
`ifdef HEX_SEG_EN
    check("h1a2b_segs", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, 7'h79, 7'h08, 7'h24, 7'h03});
`endif

    send_str("L1234"); send_byte(CR);
    drain_and_check("err_l4");
    send_str("X"); send_byte(CR);
    drain_and_check("err_x");
    send_str("H"); send_byte(CR);
    drain_and_check("err_h0");
    send_byte(CR); send_byte(LF);
    drain_and_check("crlf");

    // Back-pressure: status stalls the parser while the FIFO keeps filling.
    tx_ready_fix = 1'b0;
    repeat (2) @(posedge m_clock); #1;
    send_str("L1"); send_byte(CR);
    repeat (6) @(posedge m_clock);
    @(negedge m_clock);
    check("bp_ledg_first", {22'd0, LEDG}, 32'd1);
    check("bp_tx_valid", {31'd0, tx_valid}, 32'd1);
    check("bp_tx_data", {24'd0, tx_data}, {24'd0, ACK_K});
    @(posedge m_clock); #1;
    pend_q.delete();
    add_pend("L2"); pend_q.push_back(CR);
    add_pend("L3"); pend_q.push_back(CR);
    add_pend("HABCD"); pend_q.push_back(CR);
    add_pend("L07"); pend_q.push_back(CR);
    add_pend("X"); pend_q.push_back(CR); pend_q.push_back(LF);
    fill_until_full(accepted);
    check("bp_accepted", 32'(accepted), 32'd16);
    check("bp_rx_ready_full", {31'd0, rx_ready}, 32'd0);
    @(posedge m_clock); #1;
    tx_ready_fix = 1'b1;
    while (pend_q.size() > 0) send_byte(pend_q.pop_front());
    drain_and_check("bp");

    // Reset in the middle of a command.
    send_str("H12");
    repeat (5) @(posedge m_clock); #1;
    p_reset = 1'b1;
    model_reset();
    repeat (2) @(posedge m_clock);
    @(negedge m_clock);
    check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_ledg", {22'd0, LEDG}, 32'd0);
    check("mid_rst_hex", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, exp_hex()});
    @(posedge m_clock); #1;
    p_reset = 1'b0;
    @(posedge m_clock); #1;
    send_str("H5"); send_byte(CR);
    drain_and_check("after_rst");

    // Randomized lines with random host readiness.
    rand_ready = 1'b1;
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 10; i++) send_random_line();
      drain_and_check("rand");
    end
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vjtag_cmd_parser.md
# vjtag_cmd_parser

Byte-stream command decoder sitting directly downstream of the virtual-JTAG UART channel in the DE0 test design. It buffers host bytes in a small FIFO, parses ASCII commands that set the green LEDs and the four 7-segment digits, and returns a one-byte status to the host over the same channel. Its outputs drive LEDG and HEX0..HEX3 on the board top.

## Interface
- FIFO_DEPTH, 16, receive FIFO depth in bytes; must be a power of two, at least 2.
- m_clock  in  1  system clock, 50 MHz.
- p_reset  in  1  reset; asynchronous, active-high.
- rx_data  in  8  byte from the JTAG UART receive side.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  FIFO can accept a byte (FIFO not full).
- tx_data  out  8  status byte to the host.
- tx_valid  out  1  tx_data is valid; held until accepted.
- tx_ready  in  1  host side accepts tx_data this cycle.
- LEDG  out  10  LED register.
- HEX0..HEX3  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX0 shows the least significant nibble.

## Operation
- FIFO push on rx_valid && rx_ready. rx_ready = !full, derived from registered occupancy; a byte offered while full is not taken, and the source holds it.
- Parser pops one byte per cycle when the FIFO is non-empty and tx_valid is low.
- Hex digits: 0-9, A-F, a-f. Terminators: CR (0x0D) and LF (0x0A).
- Commands: 'L' + 1..3 hex digits + terminator loads LEDG with value[9:0]. 'H' + 1..4 hex digits + terminator loads the 16-bit display value.
- Accumulator: acc <= {acc[11:0], nibble}. The digit count is tracked per command.
- States: IDLE, CMD_L, CMD_H, DISCARD.
- IDLE:
  - 'L' or 'H' clears acc and the digit count, then moves to CMD_L or CMD_H.
  - A terminator is ignored, so CRLF pairs are harmless.
  - Any other byte goes to DISCARD.
- CMD_L / CMD_H:
  - A hex digit is accumulated.
  - A terminator with a digit count of 1 or more commits the value, queues 'K' (0x4B) and returns to IDLE.
  - A terminator with zero digits queues 'E' (0x45) and returns to IDLE.
  - A non-hex, non-terminator byte, or a digit beyond the limit (3 for L, 4 for H), goes to DISCARD.
- DISCARD: drops bytes until a terminator, then queues 'E' and returns to IDLE.
- Status: queuing sets tx_valid with tx_data. It clears on tx_valid && tx_ready.
- Reset: clears the FIFO and moves the parser to IDLE. Outputs take these values:
  - LEDG = 0 and display value = 0.
  - tx_valid = 0 and tx_data = 0x00.
  - rx_ready = 1 from the first clock after reset deasserts.
- Reset mid-command abandons the partial command. No status byte is sent.

## Timing
- Byte-to-pop latency: a byte pushed in cycle n is poppable in cycle n+1 at the earliest.
- Commit: LEDG or the display value updates on the clock edge that pops the terminator. tx_valid rises on the same edge.
- Back-pressure: while tx_valid = 1 no pop occurs, and the FIFO continues to accept bytes until full.
- Simultaneous push and pop: allowed when not full, and occupancy is unchanged. When the FIFO is empty, a pushed byte is not popped in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is log2(FIFO_DEPTH)+1.
- HEX outputs are registered: they update one cycle after the display value changes, or combinationally from it. Either way they are stable by the cycle after commit.

## Configuration
- HEX_SEG_EN defined: the nibble-to-7-segment decoder is compiled in. Each digit shows 0-F; the reset display is "0000", i.e. 7'h40 on each HEX output.
- HEX_SEG_EN undefined: the decoder and display register are omitted, and HEX0..HEX3 are tied to 7'h7F (blank). 'H' commands are still parsed and acknowledged with 'K', but have no visible effect.

## Test plan
- Reset, then "L3FF\r": LEDG = 10'h3FF, one 'K' (0x4B) on tx, rx_ready = 1 throughout.
- "H1a2B\n", HEX_SEG_EN defined: HEX3..HEX0 = 1,A,2,B → 7'h79, 7'h08, 7'h24, 7'h03; one 'K'.
- Error cases, each followed by LEDG and display unchanged:
  - "L1234\r" sends 'E'.
  - "X\r" sends 'E'.
  - "H\r" sends 'E'.
  - "\r\n" alone sends nothing.
- Back-pressure: hold tx_ready = 0 and send "L1\rL2\r" plus 16 more bytes. Required response:
  - rx_ready drops once 16 bytes are buffered.
  - LEDG = 1 after the first command.
  - Releasing tx_ready yields 'K' then continues parsing with no byte lost.
- Assert p_reset after "H12": tx_valid = 0, the display reads "0000", and a following "H5\r" shows "0005" and returns 'K'.
